// File: rtl/scm_mw_write_arbiter.sv
// scm_mw_write_arbiter
//
// Write-port controller for the multi-way latch-based register file (one write port,
// NB_WAYS ways). It shares the single SCM write port between N_REQ requesters using
// round-robin arbitration. The way mask is re-timed by one cycle so that it is valid
// while the latches are transparent. Because the latch array has no reset, the block
// also runs a zero-initialisation sweep over every word and way.
//
// Ports
//   clk, rst_n     clock; synchronous active-low reset
//   init_req_i     pulse that starts an init sweep (only honoured while arbitrating)
//   init_busy_o    high while the init sweep runs
//   req_valid_i    per-requester write request
//   req_ready_o    per-requester grant (one-hot); transfer on valid & ready
//   req_addr_i     packed word addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data_i     packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_way_i      packed way masks, requester i at [i*NB_WAYS +: NB_WAYS]
//   we_o           SCM WriteEnable
//   waddr_o        SCM WriteAddr
//   wdata_o        SCM WriteData
//   wway_o         SCM WriteWay, registered one cycle behind we_o
module scm_mw_write_arbiter #(
    parameter int unsigned NB_WAYS       = 4,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned N_REQ         = 3,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_req_i,
    output logic                          init_busy_o,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data_i,
    input  logic [N_REQ*NB_WAYS-1:0]      req_way_i,
    output logic                          we_o,
    output logic [ADDR_WIDTH-1:0]         waddr_o,
    output logic [DATA_WIDTH-1:0]         wdata_o,
    output logic [NB_WAYS-1:0]            wway_o
);

    localparam int unsigned           PtrW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] LastWord = '1;
    localparam logic [PtrW-1:0]       LastReq  = PtrW'(N_REQ - 1);

    typedef enum logic [0:0] {StInit, StArb} state_e;

    localparam state_e ResetState = INIT_ON_RESET ? StInit : StArb;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]         ptr_q, ptr_d;
    logic [NB_WAYS-1:0]      wway_q, wway_d;

    logic                    gnt_found;
    logic [PtrW-1:0]         gnt_idx;
    logic [ADDR_WIDTH-1:0]   gnt_addr;
    logic [DATA_WIDTH-1:0]   gnt_data;
    logic [NB_WAYS-1:0]      gnt_way;

    logic                    we;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [N_REQ-1:0]        ready;

    // Round-robin pick: first valid requester at or after ptr_q, wrapping modulo N_REQ.
    // The winner's address, data and way mask are muxed out alongside the index.
    always_comb begin : arbiter
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_addr  = '0;
        gnt_data  = '0;
        gnt_way   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!gnt_found && req_valid_i[idx[PtrW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[PtrW-1:0];
                gnt_addr  = req_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_data  = req_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
                gnt_way   = req_way_i[idx*NB_WAYS +: NB_WAYS];
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        wway_d  = wway_q;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        ready   = '0;

        unique case (state_q)
            StInit: begin
                // Zero every way of word cnt_q; requesters are held off entirely.
                we     = 1'b1;
                waddr  = cnt_q;
                wway_d = '1;
                if (cnt_q == LastWord) begin
                    state_d = StArb;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StArb: begin
                if (gnt_found) begin
                    we             = 1'b1;
                    waddr          = gnt_addr;
                    wdata          = gnt_data;
                    ready[gnt_idx] = 1'b1;
                    wway_d         = gnt_way;
                    ptr_d          = (gnt_idx == LastReq) ? '0 : gnt_idx + 1'b1;
                end
                // A grant in the same cycle still completes; the sweep starts next cycle.
                if (init_req_i) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ResetState;
                cnt_d   = '0;
            end
        endcase

        // Keep the SCM and requesters quiet while reset is held.
        if (!rst_n) begin
            we    = 1'b0;
            ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ResetState;
            cnt_q   <= '0;
            ptr_q   <= '0;
            wway_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            wway_q  <= wway_d;
        end
    end

    assign we_o        = we;
    assign waddr_o     = waddr;
    assign wdata_o     = wdata;
    assign req_ready_o = ready;
    assign wway_o      = wway_q;
    assign init_busy_o = rst_n ? (state_q == StInit) : INIT_ON_RESET;

endmodule

// File: tb/tb_scm_mw_write_arbiter.sv
// Self-checking bench for scm_mw_write_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural model of the arbiter and the SCM contents.
module tb_scm_mw_write_arbiter;

    localparam int NW     = 4;
    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int NR     = 3;
    localparam int NWORDS = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_req = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR*NW-1:0]  req_way = '0;

    logic              busy, we;
    logic [NR-1:0]     ready;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NW-1:0]     wway;

    logic              busy0, we0;
    logic [NR-1:0]     ready0;
    logic [AW-1:0]     waddr0;
    logic [DW-1:0]     wdata0;
    logic [NW-1:0]     wway0;

    always #5 clk = ~clk;

    scm_mw_write_arbiter #(
        .NB_WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR), .INIT_ON_RESET(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .init_req_i(init_req), .init_busy_o(busy),
        .req_valid_i(req_valid), .req_ready_o(ready), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_way_i(req_way), .we_o(we), .waddr_o(waddr),
        .wdata_o(wdata), .wway_o(wway)
    );

    // Second instance without the reset sweep; only observed while inputs are idle.
    scm_mw_write_arbiter #(
        .NB_WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR), .INIT_ON_RESET(1'b0)
    ) u_dut_noinit (
        .clk(clk), .rst_n(rst_n), .init_req_i(init_req), .init_busy_o(busy0),
        .req_valid_i(req_valid), .req_ready_o(ready0), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_way_i(req_way), .we_o(we0), .waddr_o(waddr0),
        .wdata_o(wdata0), .wway_o(wway0)
    );

    // Reference model state
    bit            m_init;
    int            m_cnt;
    int            m_ptr;
    logic [NW-1:0] m_wway;
    logic [DW-1:0] gold [NW][NWORDS];
    logic [DW-1:0] scm  [NW][NWORDS];

    int            last_grant;
    logic          last_we;
    logic [AW-1:0] last_waddr;
    int            we_count;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = AW'($urandom_range(0, NWORDS - 1));
            req_data[i*DW +: DW] = $urandom;
            req_way[i*NW +: NW]  = NW'($urandom_range(0, 15));
        end
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, then after the edge
    // mirror the write into the SCM model using the lagged way mask and advance the model.
    task automatic step(input logic rst, input logic [NR-1:0] v, input logic ir);
        int            g;
        int            c;
        logic          cap_we;
        logic [AW-1:0] cap_a;
        logic [DW-1:0] cap_d;
        @(negedge clk);
        rst_n     = rst;
        req_valid = v;
        init_req  = ir;
        #1;
        g = -1;
        if (rst && !m_init) begin
            for (int k = 0; k < NR; k++) begin
                c = (m_ptr + k) % NR;
                if (g < 0 && v[c]) g = c;
            end
        end
        if (!rst) begin
            check_eq("rst_we", we, 0);
            check_eq("rst_ready", ready, 0);
            check_eq("rst_busy", busy, 1);
        end else if (m_init) begin
            check_eq("init_we", we, 1);
            check_eq("init_ready", ready, 0);
            check_eq("init_waddr", waddr, m_cnt);
            check_eq("init_wdata", wdata, 0);
            check_eq("init_busy", busy, 1);
        end else begin
            check_eq("arb_busy", busy, 0);
            check_eq("arb_ready", ready, (g < 0) ? 0 : (1 << g));
            check_eq("arb_we", we, (g >= 0));
            if (g >= 0) begin
                check_eq("arb_waddr", waddr, req_addr[g*AW +: AW]);
                check_eq("arb_wdata", wdata, req_data[g*DW +: DW]);
            end
        end
        cap_we     = we;
        cap_a      = waddr;
        cap_d      = wdata;
        last_grant = g;
        last_we    = we;
        last_waddr = waddr;
        if (cap_we === 1'b1) we_count++;

        @(posedge clk);
        #1;
        if (rst && cap_we === 1'b1) begin
            for (int w = 0; w < NW; w++) if (wway[w]) scm[w][cap_a] = cap_d;
        end

        if (!rst) begin
            m_init = 1'b1;
            m_cnt  = 0;
            m_ptr  = 0;
            m_wway = '0;
        end else if (m_init) begin
            for (int w = 0; w < NW; w++) gold[w][m_cnt] = '0;
            m_wway = '1;
            m_cnt++;
            if (m_cnt == NWORDS) begin
                m_init = 1'b0;
                m_cnt  = 0;
            end
        end else begin
            if (g >= 0) begin
                for (int w = 0; w < NW; w++) begin
                    if (req_way[g*NW + w]) gold[w][req_addr[g*AW +: AW]] = req_data[g*DW +: DW];
                end
                m_wway = req_way[g*NW +: NW];
                m_ptr  = (g + 1) % NR;
            end
            if (ir) begin
                m_init = 1'b1;
                m_cnt  = 0;
            end
        end
        check_eq("wway", wway, m_wway);
    endtask

    int rr_exp [11] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2, 0};

    initial begin
        for (int w = 0; w < NW; w++) begin
            for (int a = 0; a < NWORDS; a++) begin
                gold[w][a] = 'x;
                scm[w][a]  = 'x;
            end
        end
        m_init = 1'b1; m_cnt = 0; m_ptr = 0; m_wway = '0;

        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);

        // Reset sweep: 32 writes of zero, then idle; the no-init instance stays quiet.
        we_count = 0;
        for (int i = 0; i < 34; i++) begin
            step(1'b1, '0, 1'b0);
            check_eq("noinit_we", we0, 0);
            check_eq("noinit_wway", wway0, 0);
            check_eq("noinit_busy", busy0, 0);
        end
        check_eq("sweep_len", we_count, NWORDS);
        for (int w = 0; w < NW; w++) begin
            for (int a = 0; a < NWORDS; a++) check_eq("init_zero", scm[w][a], 0);
        end

        // Round robin with all valid, then with requester 1 dropped.
        for (int i = 0; i < 11; i++) begin
            rand_reqs();
            step(1'b1, (i < 7) ? 3'b111 : 3'b101, 1'b0);
            check_eq("rr_grant", last_grant, rr_exp[i]);
        end

        // Way-mask timing: two writes to word 5 on different ways.
        req_addr[0*AW +: AW] = 5'd5; req_data[0*DW +: DW] = 32'hA5A5_0001; req_way[0*NW +: NW] = 4'b0010;
        req_addr[1*AW +: AW] = 5'd5; req_data[1*DW +: DW] = 32'h0000_BEEF; req_way[1*NW +: NW] = 4'b1000;
        step(1'b1, 3'b001, 1'b0);
        check_eq("wt_way_a", wway, 4'b0010);
        step(1'b1, 3'b010, 1'b0);
        check_eq("wt_way_b", wway, 4'b1000);
        step(1'b1, 3'b000, 1'b0);
        check_eq("wt_way_hold", wway, 4'b1000);
        check_eq("wt_scm_w1", scm[1][5], 32'hA5A5_0001);
        check_eq("wt_scm_w3", scm[3][5], 32'h0000_BEEF);

        // Init request colliding with a grant to requester 2.
        rand_reqs();
        step(1'b1, 3'b100, 1'b1);
        check_eq("coll_grant", last_grant, 2);
        for (int i = 0; i < NWORDS; i++) begin
            step(1'b1, 3'b111, 1'b0);
            check_eq("coll_nogrant", last_grant, -1);
        end
        step(1'b1, 3'b111, 1'b0);
        check_eq("coll_after", last_grant, 0);

        // Reset in the middle of a sweep restarts it from word 0.
        step(1'b1, '0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < NWORDS; i++) begin
            step(1'b1, '0, 1'b0);
            check_eq("rs_addr", last_waddr, i);
        end
        step(1'b1, '0, 1'b0);
        check_eq("rs_done_we", last_we, 0);

        // Idle: no writes, mask holds.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, '0, 1'b0);
            check_eq("idle_we", last_we, 0);
            check_eq("idle_wway", wway, 4'hF);
        end

        // Random traffic with occasional init requests and resets.
        for (int i = 0; i < 3000; i++) begin
            rand_reqs();
            step(($urandom_range(0, 399) != 0), NR'($urandom_range(0, 7)),
                 ($urandom_range(0, 59) == 0));
        end
        for (int i = 0; i < 40; i++) step(1'b1, '0, 1'b0);
        for (int w = 0; w < NW; w++) begin
            for (int a = 0; a < NWORDS; a++) check_eq("scm_final", scm[w][a], gold[w][a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
